// File: rtl/countdown_timer_pkg.sv
// +----------------------------------------------------------------------------+
// | countdown_timer_pkg : shared state encoding and default width for the      |
// |                       countdown timer                                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package countdown_timer_pkg;
  localparam int C_DEFAULT_N = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/down_counter_load.sv
// +----------------------------------------------------------------------------+
// | down_counter_load : loadable down counter that saturates at zero           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module down_counter_load #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] value,
  output logic [N-1:0] count
);

  logic [N-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (enable && (r_count != '0)) begin
      r_count <= r_count - N'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/countdown_timer.sv
// +----------------------------------------------------------------------------+
// | countdown_timer : one-shot / periodic countdown timer with reload register |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int N = C_DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         start,
  input  logic         auto_reload,
  output logic [N-1:0] counter,
  output logic         busy,
  output logic         expired
);

  localparam logic [N-1:0] C_ONE = N'(1);

  state_t       r_state;
  state_t       w_next_state;
  logic [N-1:0] r_reload;
  logic         r_busy;
  logic         r_expired;
  logic         w_expired_nxt;
  logic         w_cnt_load;
  logic         w_cnt_en;
  logic [N-1:0] w_cnt_value;
  logic [N-1:0] w_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_reload  <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_busy    <= (w_next_state == RUN);
      r_expired <= w_expired_nxt;
      if (load) begin
        r_reload <= load_value;
      end
    end
  end

  // The counter is driven only through load/enable; the terminal count either
  // decrements to zero (one-shot) or reloads from r_reload (periodic).
  always_comb begin
    w_next_state  = r_state;
    w_expired_nxt = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_en      = 1'b0;
    w_cnt_value   = r_reload;

    if (load) begin
      w_next_state = IDLE;
      w_cnt_load   = 1'b1;
      w_cnt_value  = load_value;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            w_cnt_load = 1'b1;
            if (r_reload == '0) begin
              w_next_state  = DONE;
              w_expired_nxt = 1'b1;
            end else begin
              w_next_state = RUN;
            end
          end
        end
        RUN: begin
          if (enable) begin
            if (w_count == C_ONE) begin
              w_expired_nxt = 1'b1;
              if (auto_reload) begin
                w_cnt_load = 1'b1;
              end else begin
                w_cnt_en     = 1'b1;
                w_next_state = DONE;
              end
            end else begin
              w_cnt_en = 1'b1;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  down_counter_load #(
    .N(N)
  ) u_down_counter_load (
    .clk    (clk),
    .reset  (reset),
    .enable (w_cnt_en),
    .load   (w_cnt_load),
    .value  (w_cnt_value),
    .count  (w_count)
  );

  assign counter = w_count;
  assign busy    = r_busy;
  assign expired = r_expired;

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// +----------------------------------------------------------------------------+
// | tb_countdown_timer : directed self-checking bench for countdown_timer      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_countdown_timer;

  localparam int N = 5;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         load;
  logic [N-1:0] load_value;
  logic         start;
  logic         auto_reload;
  logic [N-1:0] counter;
  logic         busy;
  logic         expired;

  int n_checks;
  int n_errors;

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .auto_reload (auto_reload),
    .counter     (counter),
    .busy        (busy),
    .expired     (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned c, input int unsigned b, input int unsigned e);
    check_val({tag, ".counter"}, counter, c);
    check_val({tag, ".busy"}, busy, b);
    check_val({tag, ".expired"}, expired, e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; enable = 1'b0; load = 1'b0; load_value = '0;
    start = 1'b0; auto_reload = 1'b0;

    // Reset with random inputs for two cycles
    for (int i = 0; i < 2; i++) begin
      enable      = 1'($urandom);
      load        = 1'($urandom);
      load_value  = N'($urandom);
      start       = 1'($urandom);
      auto_reload = 1'($urandom);
      step();
    end
    check_out("reset", 0, 0, 0);
    reset = 1'b0; enable = 1'b1; load = 1'b0; start = 1'b0; auto_reload = 1'b0;
    step();
    check_out("post_reset_idle", 0, 0, 0);

    // Start with zero reload register
    start = 1'b1;
    step();
    check_out("zero_start", 0, 0, 1);
    start = 1'b0;
    step();
    check_out("zero_start_after", 0, 0, 0);

    // One-shot of 5
    load = 1'b1; load_value = 5'd5;
    step();
    check_out("os_load", 5, 0, 0);
    load = 1'b0; start = 1'b1;
    step();
    check_out("os_start", 5, 1, 0);
    start = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      step();
      check_out("os_count", k, 1, 0);
    end
    step();
    check_out("os_expire", 0, 0, 1);
    step();
    check_out("os_done", 0, 0, 0);
    step();
    check_out("os_done_hold", 0, 0, 0);

    // Periodic of 3
    auto_reload = 1'b1;
    load = 1'b1; load_value = 5'd3;
    step();
    check_out("pr_load", 3, 0, 0);
    load = 1'b0; start = 1'b1;
    step();
    check_out("pr_start", 3, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      int unsigned exp_c;
      exp_c = (k % 3 == 0) ? 2 : ((k % 3 == 1) ? 1 : 3);
      step();
      check_out("pr_count", exp_c, 1, (exp_c == 3) ? 1 : 0);
    end

    // One-shot of 4 with a 3-cycle enable pause after the second decrement
    auto_reload = 1'b0;
    load = 1'b1; load_value = 5'd4;
    step();
    load = 1'b0; start = 1'b1;
    step();
    check_out("ps_start", 4, 1, 0);
    start = 1'b0;
    step();
    check_out("ps_dec1", 3, 1, 0);
    step();
    check_out("ps_dec2", 2, 1, 0);
    enable = 1'b0;
    // Flip auto_reload during the pause; only the terminal edge sample matters
    auto_reload = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out("ps_hold", 2, 1, 0);
    end
    auto_reload = 1'b0;
    enable = 1'b1;
    step();
    check_out("ps_dec3", 1, 1, 0);
    step();
    check_out("ps_expire", 0, 0, 1);

    // Load aborts a running countdown
    load = 1'b1; load_value = 5'd31;
    step();
    load = 1'b0; start = 1'b1;
    step();
    check_out("ab_start", 31, 1, 0);
    start = 1'b0;
    for (int k = 0; k < 10; k++) step();
    check_out("ab_run", 21, 1, 0);
    load = 1'b1; load_value = 5'd7;
    step();
    check_out("ab_load", 7, 0, 0);
    load = 1'b0;
    step();
    check_out("ab_idle", 7, 0, 0);
    start = 1'b1;
    step();
    check_out("ab_restart", 7, 1, 0);
    start = 1'b0;
    for (int k = 6; k >= 1; k--) begin
      step();
      check_out("ab_count", k, 1, 0);
    end
    step();
    check_out("ab_expire", 0, 0, 1);
    step();
    check_out("ab_nowrap", 0, 0, 0);

    // Start ignored while running
    load = 1'b1; load_value = 5'd4;
    step();
    load = 1'b0; start = 1'b1;
    step();
    step();
    check_out("rs_ignored", 3, 1, 0);

    // Reset together with start mid-run
    reset = 1'b1;
    step();
    check_out("rst_start", 0, 0, 0);
    reset = 1'b0; start = 1'b0;
    step();
    check_out("rst_idle", 0, 0, 0);
    start = 1'b1;
    step();
    check_out("rst_reload_cleared", 0, 0, 1);
    start = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
